// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
//   UART_DATA_BITS    : payload bits per frame
//   UART_BAUD_DIV_MIN : smallest legal baud divisor (bit period = div + 2)
//   uart_rx_state_t   : receiver FSM state encoding
package uart_pkg;

   localparam int unsigned UART_DATA_BITS    = 8;
   localparam int unsigned UART_BAUD_DIV_MIN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HI
   } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for an asynchronous single-bit input.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset; every stage resets to 1 (idle line level)
//   data_i : asynchronous input
//   data_o : synchronised output, STAGES cycles behind data_i
module uart_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic data_i,
   output logic data_o
);

   logic [STAGES-1:0] sync_q;

   // Shift chain; reset high so a reset never looks like a start edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], data_i};
      end
   end

   assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with 3-sample majority vote around mid-bit.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   data_i      : serial line, idle high, asynchronous to clk_i
//   baud_div_i  : bit period divisor, period = baud_div_i + 2 (latched at start detect)
//   data_o      : last good byte, held until the next good byte
//   valid_o     : one-cycle pulse when data_o is updated
//   frame_err_o : one-cycle pulse when the stop bit votes low
//   busy_o      : high whenever the receiver is not in IDLE
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      data_i,
   input  logic [31:0]               baud_div_i,
   output logic [UART_DATA_BITS-1:0] data_o,
   output logic                      valid_o,
   output logic                      frame_err_o,
   output logic                      busy_o
);

   localparam int unsigned CNT_W     = 33;
   localparam int unsigned BIT_CNT_W = $clog2(UART_DATA_BITS);

   uart_rx_state_t            state_q, state_d;
   logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [31:0]               div_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [CNT_W-1:0]          period_c;
   logic [CNT_W-1:0]          mid_c;
   logic                      rx_s;
   logic                      samp0_q, samp1_q;
   logic                      vote_c;
   logic                      tick_c;
   logic                      valid_d, ferr_d;
   logic                      shift_en_c;
   logic                      latch_div_c;

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .data_i (data_i),
      .data_o (rx_s)
   );

   // Period and mid-point in 33 bits so a full-scale divisor cannot overflow.
   assign period_c = CNT_W'(div_q) + CNT_W'(2);
   assign mid_c    = period_c >> 1;
   assign tick_c   = (cnt_q == mid_c + CNT_W'(1));
   assign vote_c   = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);

   // Next-state and pulse decode.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      valid_d     = 1'b0;
      ferr_d      = 1'b0;
      shift_en_c  = 1'b0;
      latch_div_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d     = START;
               latch_div_c = 1'b1;
            end
         end
         START: begin
            if (tick_c) begin
               if (vote_c) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         DATA: begin
            if (tick_c) begin
               shift_en_c = 1'b1;
               bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
               if (bit_cnt_q == BIT_CNT_W'(UART_DATA_BITS - 1)) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            // Return to IDLE at the stop mid-point so a start edge half a bit later is caught.
            if (tick_c) begin
               if (vote_c) begin
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HI;
               end
            end
         end
         WAIT_HI: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         valid_o     <= valid_d;
         frame_err_o <= ferr_d;
         busy_o      <= (state_d != IDLE);
         if (valid_d) begin
            data_o <= shift_q;
         end
      end
   end

   // Divisor latch and per-bit sample counter; counter idles at 0 outside a frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         if (latch_div_c) begin
            div_q <= baud_div_i;
         end
         if (state_q == IDLE || state_q == WAIT_HI) begin
            cnt_q <= '0;
         end else if (cnt_q == period_c - CNT_W'(1)) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Capture samples at M-1 and M; third sample is live rx_s at M+1. LSB first, so shift right.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         samp0_q <= 1'b1;
         samp1_q <= 1'b1;
         shift_q <= '0;
      end else begin
         if (cnt_q == mid_c - CNT_W'(1)) begin
            samp0_q <= rx_s;
         end
         if (cnt_q == mid_c) begin
            samp1_q <= rx_s;
         end
         if (shift_en_c) begin
            shift_q <= {vote_c, shift_q[UART_DATA_BITS-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected frames popped on each output pulse.
module tb_uart_rx;

   localparam int unsigned SYNC    = 2;
   localparam int          P       = 10;
   localparam int          LAT_NOM = (19 * P) / 2 + int'(SYNC) + 2;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        data_i;
   logic [31:0] baud_div_i;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        frame_err_o;
   logic        busy_o;

   exp_t        sb[$];
   int          checks    = 0;
   int          errors    = 0;
   int          cyc       = 0;
   int          fall_cyc  = 0;
   bit          lat_armed = 1'b0;
   bit          busy_seen = 1'b0;
   logic [7:0]  last_good = 8'h00;

   uart_rx #(
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .data_i      (data_i),
      .baud_div_i  (baud_div_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic expect_frame(input logic err, input logic [7:0] d);
      exp_t e;
      e.err  = err;
      e.data = d;
      sb.push_back(e);
   endtask

   // Drive one 10-bit frame, one line value per cycle; optional low spike, abort point, divisor change.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int lo_from,
                             input int lo_to, input int abort_at, input int chg_at);
      logic v;
      for (int j = 0; j < 10 * P; j++) begin
         if (j == abort_at) return;
         if (j / P == 0)      v = 1'b0;
         else if (j / P == 9) v = stop_v;
         else                 v = b[j / P - 1];
         if (j >= lo_from && j <= lo_to) v = 1'b0;
         @(negedge clk);
         data_i = v;
         if (j == 0) fall_cyc = cyc;
         if (j == chg_at) baud_div_i = 32'd20;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         data_i = 1'b1;
      end
   endtask

   // Output monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_i) begin
         if (busy_o) busy_seen = 1'b1;
         if (valid_o && frame_err_o) check("pulses_together", 32'd1, 32'd0);
         if (valid_o || frame_err_o) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("pulse_kind", 32'(frame_err_o), 32'(e.err));
               if (!e.err) begin
                  check("data", 32'(data_o), 32'(e.data));
                  last_good = e.data;
               end else begin
                  check("data_held", 32'(data_o), 32'(last_good));
               end
               if (lat_armed && valid_o) begin
                  check("latency_in_window",
                        32'((cyc - fall_cyc >= LAT_NOM - 1) && (cyc - fall_cyc <= LAT_NOM + 1)), 32'd1);
                  lat_armed = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      rst_i      = 1'b1;
      data_i     = 1'b1;
      baud_div_i = 32'd8;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_ferr", 32'(frame_err_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b0;
      idle(2 * P);

      // Single frame with latency window.
      lat_armed = 1'b1;
      expect_frame(1'b0, 8'h55);
      send_frame(8'h55, 1'b1, -1, -1, -1, -1);
      idle(2 * P);
      check("t1_drained", 32'(sb.size()), 32'd0);
      check("t1_lat_seen", 32'(lat_armed), 32'd0);
      lat_armed = 1'b0;

      // Glitch start: rejected, then a good frame.
      busy_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         data_i = 1'b0;
      end
      idle(3 * P);
      check("t2_busy_seen", 32'(busy_seen), 32'd1);
      check("t2_busy_low", 32'(busy_o), 32'd0);
      expect_frame(1'b0, 8'hA5);
      send_frame(8'hA5, 1'b1, -1, -1, -1, -1);
      idle(2 * P);

      // Framing error, line held low 5P from stop start.
      expect_frame(1'b1, 8'h00);
      send_frame(8'h3C, 1'b0, -1, -1, -1, -1);
      repeat (4 * P) begin
         @(negedge clk);
         data_i = 1'b0;
      end
      check("t3_busy_wait_hi", 32'(busy_o), 32'd1);
      idle(4);
      check("t3_busy_released", 32'(busy_o), 32'd0);
      idle(2 * P);

      // Back-to-back, no idle gap.
      expect_frame(1'b0, 8'hA5);
      send_frame(8'hA5, 1'b1, -1, -1, -1, -1);
      expect_frame(1'b0, 8'h3C);
      send_frame(8'h3C, 1'b1, -1, -1, -1, -1);
      expect_frame(1'b0, 8'h00);
      send_frame(8'h00, 1'b1, -1, -1, -1, -1);
      expect_frame(1'b0, 8'hFF);
      send_frame(8'hFF, 1'b1, -1, -1, -1, -1);
      idle(2 * P);

      // Noise on bit 3: single-cycle spike voted out, 3-cycle spike wins.
      expect_frame(1'b0, 8'hFF);
      send_frame(8'hFF, 1'b1, 4 * P + 6, 4 * P + 6, -1, -1);
      idle(2 * P);
      expect_frame(1'b0, 8'hF7);
      send_frame(8'hFF, 1'b1, 4 * P + 5, 4 * P + 7, -1, -1);
      idle(2 * P);

      // Reset during bit 4, then a frame with a mid-frame divisor change.
      send_frame(8'h6B, 1'b1, -1, -1, 5 * P + 3, -1);
      @(negedge clk);
      rst_i  = 1'b1;
      data_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("t6_rst_data", 32'(data_o), 32'd0);
      check("t6_rst_valid", 32'(valid_o), 32'd0);
      check("t6_rst_ferr", 32'(frame_err_o), 32'd0);
      check("t6_rst_busy", 32'(busy_o), 32'd0);
      last_good = 8'h00;
      idle(12 * P);
      expect_frame(1'b0, 8'h81);
      send_frame(8'h81, 1'b1, -1, -1, -1, 3 * P);
      baud_div_i = 32'd8;
      idle(2 * P);

      for (int i = 0; i < 20 * P && sb.size() != 0; i++) @(negedge clk);
      check("final_drain", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
